elastic_pipe2: RTL
==================

# elastic_pipe2

Two-entry elastic pipeline register with valid/ready handshakes on both sides, carrying WIDTH-bit words in order. It sits directly upstream of the team's 4-bit register pipeline stages. It decouples producer back-pressure from the consumer so a stalled consumer never drops or duplicates a word. A saturating stall counter exposes back-pressure for debug.

## Interface
- WIDTH, 4, data word width in bits
- STALL_W, 8, width of stall counter

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer offers in_data this cycle
- in_ready  output  1  block accepts a word this cycle
- in_data  input  WIDTH  producer word
- out_valid  output  1  out_data holds a valid word
- out_ready  input  1  consumer takes out_data this cycle
- out_data  output  WIDTH  oldest stored word
- occupancy  output  2  number of stored words, 0..2
- stall_cnt  output  STALL_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Push = in_valid && in_ready; pop = out_valid && out_ready; both evaluated at the same rising edge.
- Storage: main register (drives out_data) plus skid register.
- State machine EMPTY / ONE / FULL, encoded in occupancy:
  - EMPTY: push → ONE, main ← in_data; pop is impossible (out_valid=0).
  - ONE: push only → FULL, skid ← in_data; pop only → EMPTY; push and pop → stay ONE, main ← in_data.
  - FULL: pop → ONE, main ← skid; push is impossible (in_ready=0).
- Outputs decode directly from state: in_ready = (state != FULL); out_valid = (state != EMPTY).
- There are no combinational paths from in_valid or out_ready to any output.
- Words leave in arrival order. None is lost or duplicated under any in_valid/out_ready pattern.
- in_data is sampled only on push. in_valid while in_ready=0 is ignored; the producer must hold it.
- out_data holds its last value while out_valid=0. It is not cleared on pop.
- stall_cnt increments on each edge where out_valid && !out_ready. It saturates at 2^STALL_W−1 and is cleared only by reset.
- Reset, asynchronous on rst_n low: state EMPTY, main = skid = 0, stall_cnt = 0.
  - Reset values are therefore in_ready=1, out_valid=0, out_data=0, occupancy=0, stall_cnt=0.
  - Stored words are discarded.

## Timing
- Latency: a word pushed at edge N is visible on out_data with out_valid=1 after edge N, so it can be popped at edge N+1 at the earliest.
- Throughput: one word per cycle sustained when out_ready is held high.
- in_ready drops in the cycle after the second un-popped push. It rises in the cycle after the pop from FULL.
- Reset assertion mid-transfer takes effect immediately, without waiting for a clock edge.
- The first push is accepted on the first rising edge after rst_n deasserts.

## Structure
- Package elastic_pkg:
  - state enum {EMPTY=2'd0, ONE=2'd1, FULL=2'd2}; occupancy is the state encoding.
  - default WIDTH and STALL_W constants.
- Sub-module sat_counter (parameter W; inputs clk, rst_n, inc; output count): used for stall_cnt.
- All remaining logic lives in a single always_ff for the registers plus a next-state always_comb.

## Test plan
- Reset then idle:
  - rst_n low → all outputs at their reset values.
  - Release rst_n with in_valid=0 for 5 cycles → occupancy stays 0.
- Streaming:
  - out_ready=1; push 4'h1, 4'h2, 4'h3 on consecutive cycles.
  - Required: out_data 1, 2, 3 on consecutive cycles; occupancy never exceeds 1; stall_cnt = 0.
- Fill and drain:
  - out_ready=0; push 4'hA then 4'hB → in_ready=0 and occupancy=2.
  - A third in_valid with 4'hC is held and not accepted.
  - Raise out_ready → A, B, C appear in order; in_ready returns high one cycle after the first pop.
- Simultaneous push/pop in ONE:
  - Stored 4'h5; push 4'h6 with out_ready=1.
  - Required: 5 is popped; next cycle out_data=6 with occupancy=1.
- Stall saturation (STALL_W=3): hold out_valid=1, out_ready=0 for 10 cycles → stall_cnt reaches 7 and holds.
- Reset mid-operation:
  - In FULL, pulse rst_n low between clock edges → outputs go to reset values immediately.
  - Stored words never appear on out_data.

Source files
------------

// File: rtl/elastic_pkg.sv
// Shared types and defaults for the two-entry elastic pipeline register.
// Provides the occupancy/state encoding and default parameter values.
// Imported by elastic_pipe2 and its testbench.
package elastic_pkg;

    // The state encoding is the occupancy count exposed on the port.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_STALL_W = 8;

endpackage : elastic_pkg

// File: rtl/elastic_pipe2_sat_counter.sv
// Saturating up-counter: increments on each clock edge where inc=1.
// Latency: count reflects an increment one cycle after the edge that sampled inc.
// Backpressure: none. Holds at all-ones and clears only on reset.
//   Ports: clk, rst_n (async active-low), inc, count[W-1:0].
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter

// File: rtl/elastic_pipe2.sv
// Two-entry elastic pipeline register (main + skid) with valid/ready on both sides.
// Latency: one cycle from push to out_valid; sustains one word per cycle.
// Backpressure: in_ready=0 only when both entries are full; all outputs are registered.
//   Ports: clk, rst_n, in_valid/in_ready/in_data, out_valid/out_ready/out_data,
//          occupancy (0..2), stall_cnt (saturating count of stalled cycles).
module elastic_pipe2
    import elastic_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int STALL_W = DEF_STALL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         occupancy,
    output logic [STALL_W-1:0] stall_cnt
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             push;
    logic             pop;

    // Handshake outputs decode from state only, so there is no
    // combinational path from in_valid or out_ready to any output.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    // Consumer stalled: park the new word behind main.
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (pop && !push) begin
                    state_d = EMPTY;
                end else if (push && pop) begin
                    main_d = in_data;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    sat_counter #(
        .W (STALL_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid && !out_ready),
        .count (stall_cnt)
    );

endmodule : elastic_pipe2
